// File: rtl/rv_register_file.sv
// Integer register file: x1..x31 stored, x0 reads as zero; one write port, two read ports.
// Writes land on the rising clk edge while phase_writeback is high; reads are combinational.
// No backpressure: a write is accepted on every edge that has phase_writeback high.
module rv_register_file #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] rddata,
  input  logic [4:0]      rdsel,
  input  logic            phase_fetch,
  input  logic            phase_decode,
  input  logic            phase_execute,
  input  logic            phase_memory,
  input  logic            phase_writeback,
  input  logic [4:0]      rs1sel,
  input  logic [4:0]      rs2sel,
  output logic [XLEN-1:0] rs1data,
  output logic [XLEN-1:0] rs2data
);

  logic [XLEN-1:0] regs [1:31];

  // Only the write-back phase matters here; the rest are kept for a uniform core interface.
  logic unused_phases;
  assign unused_phases = phase_fetch ^ phase_decode ^ phase_execute ^ phase_memory;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (phase_writeback && (rdsel != 5'd0)) begin
      regs[rdsel] <= rddata;
    end
  end

  // No write-to-read bypass: a value written this cycle shows up after the edge.
  assign rs1data = (rs1sel == 5'd0) ? '0 : regs[rs1sel];
  assign rs2data = (rs2sel == 5'd0) ? '0 : regs[rs2sel];

endmodule

// File: tb/tb_rv_register_file.sv
// Scoreboarded bench for rv_register_file: a reference array tracks register contents,
// expected read values are queued when stimulus is driven and popped when the outputs are sampled.
module tb_rv_register_file;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [XLEN-1:0] rddata = '0;
  logic [4:0]      rdsel = '0;
  logic            phase_fetch = 1'b0;
  logic            phase_decode = 1'b0;
  logic            phase_execute = 1'b0;
  logic            phase_memory = 1'b0;
  logic            phase_writeback = 1'b0;
  logic [4:0]      rs1sel = '0;
  logic [4:0]      rs2sel = '0;
  logic [XLEN-1:0] rs1data;
  logic [XLEN-1:0] rs2data;

  int errors = 0;
  int checks = 0;
  logic [XLEN-1:0] model [32];
  logic [XLEN-1:0] exp_q [$];
  logic [XLEN-1:0] exp_v;

  rv_register_file #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .rddata(rddata), .rdsel(rdsel),
    .phase_fetch(phase_fetch), .phase_decode(phase_decode), .phase_execute(phase_execute),
    .phase_memory(phase_memory), .phase_writeback(phase_writeback),
    .rs1sel(rs1sel), .rs2sel(rs2sel), .rs1data(rs1data), .rs2data(rs2data)
  );

  always #5 clk = ~clk;

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  // One full fetch..writeback instruction; the write lands on the edge after the writeback negedge.
  task automatic run_instr(input logic [4:0] sel, input logic [XLEN-1:0] data);
    for (int p = 0; p < 5; p++) begin
      @(negedge clk);
      phase_fetch     = (p == 0);
      phase_decode    = (p == 1);
      phase_execute   = (p == 2);
      phase_memory    = (p == 3);
      phase_writeback = (p == 4);
      if (p == 4) begin
        rdsel  = sel;
        rddata = data;
      end
    end
    @(negedge clk);
    phase_writeback = 1'b0;
    phase_execute   = 1'b1;
    if (sel != 5'd0) model[sel] = data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rs1sel = i[4:0];
      exp_q.push_back(model[i]);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (rs1data !== exp_v) begin
        errors++;
        $display("FAIL reset_rs1 sel=%0d got=%h exp=%h", i, rs1data, exp_v);
      end
    end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rs2sel = i[4:0];
      exp_q.push_back(model[i]);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (rs2data !== exp_v) begin
        errors++;
        $display("FAIL reset_rs2 sel=%0d got=%h exp=%h", i, rs2data, exp_v);
      end
    end
  endtask

  task automatic test_x0();
    logic [XLEN-1:0] vals [4];
    vals[0] = 32'h0000; vals[1] = 32'hFFFF; vals[2] = 32'hAAAA; vals[3] = 32'h5555;
    for (int k = 0; k < 4; k++) begin
      rs1sel = 5'd0;
      run_instr(5'd0, vals[k]);
      exp_q.push_back(32'h0);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (rs1data !== exp_v) begin
        errors++;
        $display("FAIL x0_write data=%h got=%h exp=%h", vals[k], rs1data, exp_v);
      end
    end
  endtask

  task automatic test_per_reg();
    logic [XLEN-1:0] vals [4];
    vals[0] = 32'h0000; vals[1] = 32'hFFFF; vals[2] = 32'h5555; vals[3] = 32'hAAAA;
    for (int i = 1; i < 32; i++) begin
      for (int k = 0; k < 4; k++) begin
        rs1sel = i[4:0];
        rs2sel = i[4:0];
        run_instr(i[4:0], vals[k]);
        exp_q.push_back(vals[k]);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (rs1data !== exp_v || rs2data !== exp_v) begin
          errors++;
          $display("FAIL per_reg x%0d got1=%h got2=%h exp=%h", i, rs1data, rs2data, exp_v);
        end
      end
    end
  endtask

  task automatic test_decode();
    for (int i = 1; i < 32; i++) run_instr(i[4:0], i);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rs1sel = i[4:0];
      rs2sel = 5'(31 - i);
      exp_q.push_back(model[i]);
      exp_q.push_back(model[31 - i]);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (rs1data !== exp_v) begin
        errors++;
        $display("FAIL decode_rs1 sel=%0d got=%h exp=%h", i, rs1data, exp_v);
      end
      exp_v = exp_q.pop_front();
      checks++;
      if (rs2data !== exp_v) begin
        errors++;
        $display("FAIL decode_rs2 sel=%0d got=%h exp=%h", 31 - i, rs2data, exp_v);
      end
    end
  endtask

  task automatic test_gating();
    @(negedge clk);
    phase_execute = 1'b0;
    rdsel = 5'd5; rddata = 32'h1234; rs1sel = 5'd5;
    repeat (4) @(negedge clk);
    exp_q.push_back(model[5]);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (rs1data !== exp_v) begin
      errors++;
      $display("FAIL gating_off got=%h exp=%h", rs1data, exp_v);
    end
    phase_writeback = 1'b1;
    @(negedge clk);
    phase_writeback = 1'b0;
    model[5] = 32'h1234;
    exp_q.push_back(model[5]);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (rs1data !== exp_v) begin
      errors++;
      $display("FAIL gating_on got=%h exp=%h", rs1data, exp_v);
    end
  endtask

  // Write-back held high: one write per edge, and the old value is visible before each edge.
  task automatic test_back_to_back();
    logic [XLEN-1:0] d;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      d = $urandom;
      phase_writeback = 1'b1;
      rdsel = 5'(9 + k); rddata = d;
      rs1sel = 5'(9 + k); rs2sel = 5'(9 + k);
      exp_q.push_back(model[9 + k]);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (rs1data !== exp_v || rs2data !== exp_v) begin
        errors++;
        $display("FAIL no_bypass x%0d got1=%h got2=%h exp=%h", 9 + k, rs1data, rs2data, exp_v);
      end
      model[9 + k] = d;
    end
    @(negedge clk);
    phase_writeback = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rs1sel = 5'(9 + k);
      exp_q.push_back(model[9 + k]);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (rs1data !== exp_v) begin
        errors++;
        $display("FAIL b2b_write x%0d got=%h exp=%h", 9 + k, rs1data, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #2;
    rs1sel = 5'd3; rs2sel = 5'd31;
    rst_n = 1'b0;
    clear_model();
    exp_q.push_back(32'h0);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (rs1data !== exp_v || rs2data !== exp_v) begin
      errors++;
      $display("FAIL async_reset got1=%h got2=%h exp=%h", rs1data, rs2data, exp_v);
    end
    for (int i = 0; i < 32; i++) begin
      rs1sel = i[4:0];
      rs2sel = 5'(31 - i);
      exp_q.push_back(32'h0);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (rs1data !== exp_v || rs2data !== exp_v) begin
        errors++;
        $display("FAIL async_sweep sel=%0d got1=%h got2=%h exp=%h", i, rs1data, rs2data, exp_v);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Reset pulled during a pending write: the write is lost.
    @(negedge clk);
    phase_writeback = 1'b1; rdsel = 5'd7; rddata = 32'hDEAD_BEEF; rs1sel = 5'd7;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    phase_writeback = 1'b0;
    exp_q.push_back(model[7]);
    exp_v = exp_q.pop_front();
    checks++;
    if (rs1data !== exp_v) begin
      errors++;
      $display("FAIL reset_mid_write got=%h exp=%h", rs1data, exp_v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(5'd7, 32'hCAFE_0007);
    exp_q.push_back(model[7]);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (rs1data !== exp_v) begin
      errors++;
      $display("FAIL post_reset_write got=%h exp=%h", rs1data, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_x0();
    test_per_reg();
    test_decode();
    test_gating();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv_register_file.md
# rv_register_file

Integer register file of the RockWave core: 32 general-purpose registers of XLEN bits, x0 hardwired to zero, two combinational read ports (rs1/rs2) and one write port (rd). It sits between decode/execute, which consume rs1data/rs2data, and write-back, which supplies rddata/rdsel. Writes are gated by the core's one-hot phase sequencer (fetch → decode → execute → memory → writeback).

## Interface
- XLEN, 32, register width (value from core_general.vh)
- clk  input  1  clock; all register updates on rising edge
- rst_n  input  1  reset; one clock, asynchronous, active-low
- rddata  input  XLEN  write data
- rdsel  input  5  destination register index
- phase_fetch  input  1  fetch phase flag (unused internally)
- phase_decode  input  1  decode phase flag (unused internally)
- phase_execute  input  1  execute phase flag (unused internally)
- phase_memory  input  1  memory phase flag (unused internally)
- phase_writeback  input  1  write-back phase flag; write enable
- rs1sel  input  5  read port 1 index
- rs2sel  input  5  read port 2 index
- rs1data  output  XLEN  contents of register rs1sel
- rs2data  output  XLEN  contents of register rs2sel

## Operation
- Storage: x1..x31, each XLEN bits; x0 not stored, reads as 0.
- Reset: rst_n low clears x1..x31 to 0 immediately (asynchronous), regardless of clk or phase; held at 0 while rst_n low.
- Write: at rising clk with rst_n high, phase_writeback = 1 and rdsel ≠ 0 → x[rdsel] ← rddata. Otherwise no register changes.
- rdsel = 0: write silently discarded; x0 stays 0 for any rddata.
- Read: rs1data = (rs1sel == 0) ? 0 : x[rs1sel]; rs2data likewise. Purely combinational from sel and stored state; no phase gating.
- Both read ports independent; may select the same register, including rdsel.
- No write-to-read bypass: during the write-back cycle, reads return the old value; new value visible after the writing edge.
- Other phase inputs have no effect; present for interface uniformity.
- No X propagation from reset: all outputs defined (0) from reset assertion.

## Timing
- Reset value of rs1data/rs2data: 0 for every select while rst_n low and after release until first write.
- Write latency: value written on clk edge N (phase_writeback high) readable combinationally right after edge N.
- phase_writeback is one clk wide in normal sequencing (one write per 5-cycle instruction); if held high for multiple cycles, a write occurs on every such edge with current rddata/rdsel.
- Read latency: zero cycles; sel change → data change in same cycle.
- Reset asserted mid-write: reset wins; register cleared, pending write lost.
- Reset release: first write possible at first rising edge with rst_n high and phase_writeback high.

## Test plan
- Reset check: assert rst_n=0 for 2 cycles, release; sweep rs1sel 0..31 then rs2sel 0..31, one per cycle → all read 0.
- x0 protection: rdsel=0, write 0x0000, 0xFFFF, 0xAAAA, 0x5555 through full phase cycles → rs1sel=0 reads 0 after each.
- Per-register write/read: for i=1..31, rdsel=rs1sel=i, write 0x0000, 0xFFFF, 0x5555, 0xAAAA in successive write-back phases → rs1data equals written value after each, checked in next execute phase.
- Address decode uniqueness: write x[i]=i for i=1..31, then sweep rs1sel 0..31 → rs1data=i (0 for x0); repeat on rs2sel → rs2data=i.
- Write gating: rdsel=5, rddata=0x1234 with phase_writeback=0 across several edges → x5 unchanged; raise phase_writeback one cycle → x5=0x1234.
- Async reset mid-operation: after filling registers, pull rst_n low between clk edges → rs1data/rs2data go 0 immediately for all selects.
